rf_writeback_queue: RTL and testbench

Writer side of the 32x32 register file. It collects completed results from the ALU and load (memory) pipelines and buffers them in a small in-order queue. It drains one entry per cycle onto the register file's single write port (we/wa/wd). It also exports a busy mask so decode can stall on registers with writes still pending.

---
 rtl/rf_wb_pkg.sv | 21 ++
 rtl/rf_writeback_queue_fifo.sv | 78 +++++++
 rtl/rf_writeback_queue.sv | 106 ++++++++++
 tb/tb_rf_writeback_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback queue.
package rf_wb_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wb_entry_t;

  // One-hot decode of a register address into a 32-bit busy vector.
  function automatic logic [31:0] onehot32(input logic [AW-1:0] addr);
    logic [31:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_writeback_queue_fifo.sv
// wb_fifo: circular buffer accepting up to two pushes and one pop per cycle.
// Exports per-slot valid/address so the top can build the busy mask.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = rf_wb_pkg::DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            push_a,
  input  wb_entry_t                       data_a,
  input  logic                            push_b,
  input  wb_entry_t                       data_b,
  input  logic                            pop,
  output wb_entry_t                       head,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][AW-1:0]        ent_wa
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_b;
  logic [CW-1:0] n_push;
  logic [PW-1:0] offs;

  // push_b is only ever set together with push_a, so slot b follows slot a.
  assign wr_ptr_b = wr_ptr + PW'(1);
  assign n_push   = CW'(push_a) + CW'(push_b);
  assign head     = mem[rd_ptr];

  // Pointer and occupancy update; flush empties the queue at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + n_push - CW'(pop);
    end
  end

  // Entry storage; validity is tracked by pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= data_a;
    if (push_b) mem[wr_ptr_b] <= data_b;
  end

  // A slot is valid when its distance from the read pointer is below count.
  always_comb begin
    offs      = '0;
    ent_valid = '0;
    ent_wa    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs         = PW'(i) - rd_ptr;
      ent_valid[i] = {1'b0, offs} < count;
      ent_wa[i]    = mem[i].wa;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    (32'(count) + 32'(n_push) - 32'(pop)) <= DEPTH);

  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));

endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: merges load and ALU results into an in-order queue and
// drains one entry per cycle onto the register file write port.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = rf_wb_pkg::DEPTH,
  parameter int unsigned AW    = rf_wb_pkg::AW,
  parameter int unsigned DW    = rf_wb_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_wa,
  input  logic [DW-1:0]            mem_wd,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_wa,
  input  logic [DW-1:0]            alu_wd,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wa,
  output logic [DW-1:0]            rf_wd,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                     pop;
  logic [CW-1:0]            free;
  logic                     mem_en;
  logic                     alu_en;
  logic                     push_a;
  logic                     push_b;
  wb_entry_t                data_a;
  wb_entry_t                data_b;
  wb_entry_t                head;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_wa;

  assign pop  = (count != '0) && !flush;
  assign free = CW'(DEPTH) - count + CW'(pop);

  // Readiness depends only on flush, occupancy and mem_valid.
  assign mem_ready = !flush && (free >= CW'(1));
  assign alu_ready = !flush && ((free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid));

  // Writes to r0 complete the handshake but are dropped before the queue.
  assign mem_en = mem_valid && mem_ready && (mem_wa != '0);
  assign alu_en = alu_valid && alu_ready && (alu_wa != '0);

  // Compact accepted results into slot a (older) and slot b so the FIFO
  // never has a gap; mem is older than alu when both land together.
  always_comb begin
    push_a    = mem_en || alu_en;
    push_b    = mem_en && alu_en;
    data_a.wa = mem_en ? mem_wa : alu_wa;
    data_a.wd = mem_en ? mem_wd : alu_wd;
    data_b.wa = alu_wa;
    data_b.wd = alu_wd;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push_a    (push_a),
    .data_a    (data_a),
    .push_b    (push_b),
    .data_b    (data_b),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_wa    (ent_wa)
  );

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (pop) begin
      rf_we <= 1'b1;
      rf_wa <= head.wa;
      rf_wd <= head.wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Busy mask: every queued destination plus the write currently on the port.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy_mask = busy_mask | onehot32(ent_wa[i]);
    end
    if (rf_we) busy_mask = busy_mask | onehot32(rf_wa);
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized and directed bench for rf_writeback_queue against a queue model.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;
  logic [2:0]  count;

  always #5 clk = ~clk;

  rf_writeback_queue #(
    .DEPTH(DEPTH),
    .AW(5),
    .DW(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .busy_mask (busy_mask),
    .count     (count)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          checks = 0;
  int          errors = 0;
  bit          saw_full = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (q[i]) b[q[i].wa] = 1'b1;
    if (m_we) b[m_wa] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rf_we"}, 64'(rf_we), 64'(m_we));
    check({tag, ".rf_wa"}, 64'(rf_wa), 64'(m_wa));
    check({tag, ".rf_wd"}, 64'(rf_wd), 64'(m_wd));
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".busy"},  64'(busy_mask), 64'(model_busy()));
  endtask

  // One cycle: drive at negedge, check readies, model the edge, check outputs.
  task automatic step(input logic f, input logic mv, input logic [4:0] mwa, input logic [31:0] mwd,
                      input logic av, input logic [4:0] awa, input logic [31:0] awd);
    int   free;
    logic exp_mr;
    logic exp_ar;
    flush     = f;
    mem_valid = mv;
    mem_wa    = mwa;
    mem_wd    = mwd;
    alu_valid = av;
    alu_wa    = awa;
    alu_wd    = awd;
    #1;
    free   = DEPTH - q.size() + (((q.size() > 0) && !f) ? 1 : 0);
    exp_mr = !f && (free >= 1);
    exp_ar = !f && ((free >= 2) || ((free >= 1) && !mv));
    check("mem_ready", 64'(mem_ready), 64'(exp_mr));
    check("alu_ready", 64'(alu_ready), 64'(exp_ar));
    if (q.size() == DEPTH && mv && !f) begin
      saw_full = 1'b1;
      check("full.mem_ready", 64'(mem_ready), 64'd1);
      check("full.alu_ready", 64'(alu_ready), 64'd0);
    end
    @(posedge clk);
    if (f) begin
      m_we = 1'b0;
      q.delete();
    end else begin
      if (q.size() > 0) begin
        m_we = 1'b1;
        m_wa = q[0].wa;
        m_wd = q[0].wd;
        void'(q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (mv && exp_mr && mwa != 5'd0) q.push_back('{mwa, mwd});
      if (av && exp_ar && awa != 5'd0) q.push_back('{awa, awd});
    end
    @(negedge clk);
    check_state("cyc");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    model_reset();
    #3;
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single ALU push: visible on the port one edge after acceptance.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    check("t1.count", 64'(count), 64'd1);
    check("t1.busy5_q", 64'(busy_mask[5]), 64'd1);
    check("t1.we_lat", 64'(rf_we), 64'd0);
    idle();
    check("t1.we", 64'(rf_we), 64'd1);
    check("t1.wa", 64'(rf_wa), 64'd5);
    check("t1.wd", 64'(rf_wd), 64'h1234);
    check("t1.busy5_port", 64'(busy_mask[5]), 64'd1);
    idle();
    check("t1.busy_clear", 64'(busy_mask), 64'd0);

    // Dual push into empty queue: mem first, then alu.
    step(1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
    check("t2.count2", 64'(count), 64'd2);
    idle();
    check("t2.wa3", 64'(rf_wa), 64'd3);
    check("t2.count1", 64'(count), 64'd1);
    idle();
    check("t2.wa4", 64'(rf_wa), 64'd4);
    check("t2.count0", 64'(count), 64'd0);
    idle();

    // Fill to full with both channels valid and distinct addresses.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 5'(2*i + 1), 32'(32'h100 + i), 1'b1, 5'(2*i + 2), 32'(32'h200 + i));
    check("t3.full_reached", 64'(saw_full), 64'd1);
    for (int i = 0; i < 6; i++) idle();

    // Zero register: handshake completes, nothing queued.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    check("t4.count", 64'(count), 64'd0);
    check("t4.busy", 64'(busy_mask), 64'd0);
    idle();
    check("t4.we", 64'(rf_we), 64'd0);

    // Flush with three entries queued and a write on the port.
    step(1'b0, 1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
    step(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
    check("t5.pre_count", 64'(count), 64'd3);
    check("t5.pre_we", 64'(rf_we), 64'd1);
    step(1'b1, 1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
    check("t5.count", 64'(count), 64'd0);
    check("t5.busy", 64'(busy_mask), 64'd0);
    check("t5.we", 64'(rf_we), 64'd0);

    // Async reset between edges with two entries queued.
    step(1'b0, 1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF);
    check("t6.pre_count", 64'(count), 64'd2);
    check("t6.pre_we", 64'(rf_we), 64'd1);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t6.count", 64'(count), 64'd0);
    check("t6.we", 64'(rf_we), 64'd0);
    check("t6.busy", 64'(busy_mask), 64'd0);
    check_state("t6.rst");
    #1 rst = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'h17);
    idle();
    check("t6.resume_wa", 64'(rf_wa), 64'd17);
    check("t6.resume_wd", 64'(rf_wd), 64'h17);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
    end
    for (int i = 0; i < 6; i++) idle();
    check("final.count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
